// File: rtl/ram_word_sender_pkg.sv
// Shared types and widths for the RAM word sender (24-bit words sent as three UART bytes).
// Build option: RAM_WORD_SENDER_CHECKSUM_EN adds the CSUM state for a trailing XOR byte.
package ram_word_sender_pkg;

   localparam int unsigned BYTES_PER_WORD = 3;
   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
   localparam int unsigned IDX_W          = 2;

`ifdef RAM_WORD_SENDER_CHECKSUM_EN
   typedef enum logic [3:0] {
      IDLE, RD_REQ, RD_WAIT, LOAD, SEND, WAIT_HI, WAIT_LO, NEXT, CSUM, FINISH
   } state_t;
`else
   typedef enum logic [3:0] {
      IDLE, RD_REQ, RD_WAIT, LOAD, SEND, WAIT_HI, WAIT_LO, NEXT, FINISH
   } state_t;
`endif

endpackage

// File: rtl/ram_word_sender_if.sv
// RAM read port and UART tx port bundle; master is the sender, slave is the RAM/UART side.
interface ram_word_sender_if #(
   parameter int unsigned ADDR_W = 10
);
   import ram_word_sender_pkg::*;

   logic              ram_rd_en;
   logic [ADDR_W-1:0] ram_addr;
   logic [WORD_W-1:0] ram_rdata;
   logic              tx_busy;
   logic              tx_start;
   logic [BYTE_W-1:0] tx_data;

   modport master (
      output ram_rd_en, ram_addr, tx_start, tx_data,
      input  ram_rdata, tx_busy
   );

   modport slave (
      input  ram_rd_en, ram_addr, tx_start, tx_data,
      output ram_rdata, tx_busy
   );

endinterface

// File: rtl/ram_word_sender_tx_byte_handshake.sv
// Hands a single byte to the UART: wait idle, pulse tx_start, wait busy high then low.
module tx_byte_handshake
   import ram_word_sender_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   input  logic [BYTE_W-1:0] data,
   input  logic              tx_busy,
   output logic              tx_start,
   output logic [BYTE_W-1:0] tx_data,
   output logic              byte_done
);

   state_t            state;
   logic [BYTE_W-1:0] hold;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         hold      <= '0;
         tx_start  <= 1'b0;
         tx_data   <= '0;
         byte_done <= 1'b0;
      end else begin
         tx_start  <= 1'b0;
         byte_done <= 1'b0;
         case (state)
            IDLE: begin
               if (go) begin
                  hold  <= data;
                  state <= SEND;
               end
            end
            SEND: begin
               if (!tx_busy) begin
                  tx_start <= 1'b1;
                  tx_data  <= hold;
                  state    <= WAIT_HI;
               end
            end
            // busy rising means the UART has latched tx_data
            WAIT_HI: begin
               if (tx_busy) state <= WAIT_LO;
            end
            WAIT_LO: begin
               if (!tx_busy) begin
                  byte_done <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/ram_word_sender.sv
// Reads word_count 24-bit RAM words from base_addr and sends each LSB-first as three UART bytes.
// Build option: RAM_WORD_SENDER_CHECKSUM_EN appends an XOR checksum byte after the last word.
module ram_word_sender
   import ram_word_sender_pkg::*;
#(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned RAM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] word_count,
   ram_word_sender_if.master bus,
   output logic              busy,
   output logic              done
);

   localparam logic [1:0]       LAT_LAST = 2'(RAM_LAT > 1 ? RAM_LAT - 2 : 0);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] words_left;
   logic [ADDR_W-1:0] ram_addr_q;
   logic              ram_rd_en_q;
   logic [WORD_W-1:0] shift_reg;
   logic [IDX_W-1:0]  byte_idx;
   logic [1:0]        lat_cnt;
   logic              go;
   logic              byte_done;
   logic [BYTE_W-1:0] hs_data;
   logic [ADDR_W-1:0] addr_inc;
   logic [ADDR_W-1:0] words_dec;

   assign addr_inc      = addr + ADDR_W'(1);
   assign words_dec     = words_left - ADDR_W'(1);
   assign bus.ram_rd_en = ram_rd_en_q;
   assign bus.ram_addr  = ram_addr_q;

`ifdef RAM_WORD_SENDER_CHECKSUM_EN
   logic [BYTE_W-1:0] csum;
   assign hs_data = (state == CSUM) ? csum : shift_reg[BYTE_W-1:0];
`else
   assign hs_data = shift_reg[BYTE_W-1:0];
`endif

   tx_byte_handshake u_hs (
      .clk       (clk),
      .reset     (reset),
      .go        (go),
      .data      (hs_data),
      .tx_busy   (bus.tx_busy),
      .tx_start  (bus.tx_start),
      .tx_data   (bus.tx_data),
      .byte_done (byte_done)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         addr        <= '0;
         words_left  <= '0;
         ram_addr_q  <= '0;
         ram_rd_en_q <= 1'b0;
         shift_reg   <= '0;
         byte_idx    <= '0;
         lat_cnt     <= '0;
         go          <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
`ifdef RAM_WORD_SENDER_CHECKSUM_EN
         csum        <= '0;
`endif
      end else begin
         ram_rd_en_q <= 1'b0;
         go          <= 1'b0;
         done        <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
`ifdef RAM_WORD_SENDER_CHECKSUM_EN
                  csum <= '0;
`endif
                  if (word_count != '0) begin
                     addr        <= base_addr;
                     words_left  <= word_count;
                     ram_addr_q  <= base_addr;
                     ram_rd_en_q <= 1'b1;
                     state       <= RD_REQ;
                  end else begin
                     state <= FINISH;
                  end
               end
            end
            RD_REQ: begin
               lat_cnt <= '0;
               state   <= (RAM_LAT > 1) ? RD_WAIT : LOAD;
            end
            RD_WAIT: begin
               if (lat_cnt == LAT_LAST) state <= LOAD;
               else                     lat_cnt <= lat_cnt + 2'd1;
            end
            LOAD: begin
               shift_reg <= bus.ram_rdata;
               byte_idx  <= '0;
               go        <= 1'b1;
               state     <= SEND;
            end
            // Byte handshake runs in the sub-module; advance on each completed byte
            SEND: begin
               if (byte_done) begin
                  shift_reg <= shift_reg >> BYTE_W;
`ifdef RAM_WORD_SENDER_CHECKSUM_EN
                  csum      <= csum ^ shift_reg[BYTE_W-1:0];
`endif
                  if (byte_idx != LAST_IDX) begin
                     byte_idx <= byte_idx + IDX_W'(1);
                     go       <= 1'b1;
                  end else begin
                     state <= NEXT;
                  end
               end
            end
            NEXT: begin
               addr       <= addr_inc;
               words_left <= words_dec;
               if (words_dec != '0) begin
                  ram_addr_q  <= addr_inc;
                  ram_rd_en_q <= 1'b1;
                  state       <= RD_REQ;
               end else begin
`ifdef RAM_WORD_SENDER_CHECKSUM_EN
                  go    <= 1'b1;
                  state <= CSUM;
`else
                  state <= FINISH;
`endif
               end
            end
`ifdef RAM_WORD_SENDER_CHECKSUM_EN
            CSUM: begin
               if (byte_done) state <= FINISH;
            end
`endif
            FINISH: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_word_sender.sv
// Bench for ram_word_sender: RAM and UART models, queue-based reference of expected reads/bytes.
`timescale 1ns/1ps
module tb_ram_word_sender;
   import ram_word_sender_pkg::*;

   localparam int unsigned ADDR_W  = 10;
   localparam int unsigned RAM_LAT = 1;
   localparam int unsigned DEPTH   = 1 << ADDR_W;
   localparam int          LIMIT   = 3000;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W-1:0] word_count = '0;
   logic              busy;
   logic              done;

   ram_word_sender_if #(.ADDR_W(ADDR_W)) bus ();

   ram_word_sender #(.ADDR_W(ADDR_W), .RAM_LAT(RAM_LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .bus        (bus),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // RAM: data appears exactly RAM_LAT cycles after the strobe, zero otherwise
   logic [23:0] mem [DEPTH];
   logic [23:0] pipe [RAM_LAT];
   always @(posedge clk) begin
      pipe[0] <= bus.ram_rd_en ? mem[bus.ram_addr] : 24'h0;
      for (int i = 1; i < int'(RAM_LAT); i++) pipe[i] <= pipe[i-1];
   end
   assign bus.ram_rdata = pipe[RAM_LAT-1];

   // UART: busy for busy_len cycles after each tx_start, plus an external override
   int   ucnt = 0;
   int   busy_len = 10;
   logic force_busy = 1'b0;
   always @(posedge clk) begin
      if (bus.tx_start)  ucnt <= busy_len;
      else if (ucnt > 0) ucnt <= ucnt - 1;
   end
   assign bus.tx_busy = (ucnt != 0) || force_busy;

   logic [ADDR_W-1:0] rd_q [$];
   logic [7:0]        tx_q [$];
   int                done_cnt = 0;
   always @(negedge clk) begin
      if (bus.ram_rd_en) rd_q.push_back(bus.ram_addr);
      if (bus.tx_start)  tx_q.push_back(bus.tx_data);
      if (done)          done_cnt++;
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [ADDR_W-1:0] exp_a [$];
   logic [7:0]        exp_b [$];

   // Reference: consecutive addresses modulo DEPTH, bytes low to high, optional XOR tail
   task automatic model(input int b, input int n);
      logic [7:0]  x;
      logic [23:0] w;
      exp_a.delete();
      exp_b.delete();
      x = 8'h0;
      for (int i = 0; i < n; i++) begin
         exp_a.push_back(ADDR_W'((b + i) % int'(DEPTH)));
         w = mem[(b + i) % int'(DEPTH)];
         for (int k = 0; k < 3; k++) begin
            exp_b.push_back(8'((w / (24'h1 << (8 * k))) % 256));
            x = x ^ exp_b[exp_b.size()-1];
         end
      end
`ifdef RAM_WORD_SENDER_CHECKSUM_EN
      if (n != 0) exp_b.push_back(x);
`endif
   endtask

   task automatic launch(input string tag, input int b, input int n);
      rd_q.delete();
      tx_q.delete();
      done_cnt = 0;
      @(negedge clk);
      start = 1'b1;
      base_addr = ADDR_W'(b);
      word_count = ADDR_W'(n);
      @(negedge clk);
      start = 1'b0;
      check({tag, ":busy_after_start"}, 32'(busy), 32'd1);
   endtask

   task automatic await_done(input string tag, output int cyc);
      cyc = 0;
      while (!done && cyc < LIMIT) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, ":done_seen"}, 32'(done), 32'd1);
      check({tag, ":busy_at_done"}, 32'(busy), 32'd0);
      @(negedge clk);
      check({tag, ":done_single"}, 32'(done), 32'd0);
      check({tag, ":done_count"}, 32'(done_cnt), 32'd1);
   endtask

   task automatic compare(input string tag);
      check({tag, ":n_reads"}, 32'(rd_q.size()), 32'(exp_a.size()));
      check({tag, ":n_bytes"}, 32'(tx_q.size()), 32'(exp_b.size()));
      for (int i = 0; i < exp_a.size() && i < rd_q.size(); i++)
         check($sformatf("%s:addr%0d", tag, i), 32'(rd_q[i]), 32'(exp_a[i]));
      for (int i = 0; i < exp_b.size() && i < tx_q.size(); i++)
         check($sformatf("%s:byte%0d", tag, i), 32'(tx_q[i]), 32'(exp_b[i]));
   endtask

   task automatic run_xfer(input string tag, input int b, input int n);
      int cyc;
      model(b, n);
      launch(tag, b, n);
      await_done(tag, cyc);
      compare(tag);
   endtask

   initial begin
      int cyc;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = 24'($urandom);
      mem[5]     = 24'hA1B2C3;
      mem[41]    = 24'h5A5A5A;
      mem[12'h10] = 24'h010203;
      mem[12'h11] = 24'h040506;

      #1;
      check("rst:ram_rd_en", 32'(bus.ram_rd_en), 32'd0);
      check("rst:ram_addr",  32'(bus.ram_addr),  32'd0);
      check("rst:tx_start",  32'(bus.tx_start),  32'd0);
      check("rst:tx_data",   32'(bus.tx_data),   32'd0);
      check("rst:busy",      32'(busy),          32'd0);
      check("rst:done",      32'(done),          32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;

      run_xfer("single", 5, 1);
      run_xfer("wrap", 'h3FE, 3);

      // Zero-length: done two cycles after start, no traffic
      model(0, 0);
      launch("zero", 7, 0);
      await_done("zero", cyc);
      check("zero:latency", 32'(cyc + 1), 32'd2);
      compare("zero");

      // UART held busy: nothing may be sent; a second start is ignored
      force_busy = 1'b1;
      model(20, 2);
      launch("hold", 20, 2);
      repeat (50) @(negedge clk);
      check("hold:no_tx", 32'(tx_q.size()), 32'd0);
      check("hold:one_read", 32'(rd_q.size()), 32'd1);
      start = 1'b1; base_addr = ADDR_W'(100); word_count = ADDR_W'(5);
      @(negedge clk);
      start = 1'b0;
      force_busy = 1'b0;
      await_done("hold", cyc);
      compare("hold");

      // Reset during the second word's byte handshake
      model(40, 3);
      launch("abort", 40, 3);
      cyc = 0;
      while (tx_q.size() < 5 && cyc < LIMIT) begin
         @(negedge clk);
         cyc++;
      end
      check("abort:reached_word2", 32'(tx_q.size() >= 5), 32'd1);
      repeat (3) @(negedge clk);
      check("abort:pre_tx_data", 32'(bus.tx_data != 8'h0), 32'd1);
      reset = 1'b0;
      #1;
      check("abort:ram_rd_en", 32'(bus.ram_rd_en), 32'd0);
      check("abort:ram_addr",  32'(bus.ram_addr),  32'd0);
      check("abort:tx_start",  32'(bus.tx_start),  32'd0);
      check("abort:tx_data",   32'(bus.tx_data),   32'd0);
      check("abort:busy",      32'(busy),          32'd0);
      check("abort:done",      32'(done),          32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      cyc = 0;
      while (bus.tx_busy && cyc < LIMIT) begin
         @(negedge clk);
         cyc++;
      end
      check("abort:no_done", 32'(done_cnt), 32'd0);
      run_xfer("after_rst", 0, 1);

      run_xfer("csum", 'h10, 2);
`ifdef RAM_WORD_SENDER_CHECKSUM_EN
      if (tx_q.size() == 7) check("csum:value", 32'(tx_q[6]), 32'h07);
      else                  check("csum:len", 32'(tx_q.size()), 32'd7);
`endif

      for (int t = 0; t < 6; t++) begin
         busy_len = int'($urandom_range(1, 12));
         run_xfer($sformatf("rnd%0d", t), int'($urandom_range(0, DEPTH - 1)),
                  int'($urandom_range(1, 4)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram_word_sender.md
Name: ram_word_sender

Overview:
- Read-back path for the serial link.
- Reads 24-bit words from the display/frame RAM, splits each into three bytes and hands them one at a time to the UART transmitter.
- Byte order mirrors the receive-side assembler: byte 0 = [7:0], byte 1 = [15:8], byte 2 = [23:16].
- Sits between the RAM read port and the UART tx core; started by a single-cycle command from the control logic.

Parameters:
- ADDR_W, 10, RAM address width; address arithmetic wraps modulo 2^ADDR_W.
- RAM_LAT, 1, RAM read latency in cycles (1..3) from ram_rd_en to valid ram_rdata.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  one-cycle request to begin a transfer; honoured only in IDLE
- base_addr  input  ADDR_W  first RAM address, sampled with start
- word_count  input  ADDR_W  number of words to send, sampled with start
- ram_rd_en  output  1  RAM read strobe
- ram_addr  output  ADDR_W  RAM read address
- ram_rdata  input  24  RAM read data
- tx_busy  input  1  UART tx busy; high while a byte is shifting out
- tx_start  output  1  one-cycle pulse; UART latches tx_data
- tx_data  output  8  byte to transmit
- busy  output  1  high from the cycle after start acceptance until done
- done  output  1  one-cycle pulse at end of transfer

Behaviour:
- Reset values (asynchronous on reset=0): state IDLE; ram_rd_en, ram_addr, tx_start, tx_data, busy, done all 0; internal counters and shift register 0.
- Reset mid-transfer aborts immediately. No done pulse. Any byte already started in the UART is not tracked.
- States: IDLE, RD_REQ, RD_WAIT, LOAD, SEND, WAIT_HI, WAIT_LO, NEXT, FINISH.
- IDLE:
  - start=1 and word_count!=0: capture addr<=base_addr, words_left<=word_count, go RD_REQ.
  - start=1 and word_count=0: go FINISH (done pulse, no RAM read, no tx).
  - start while not IDLE is ignored.
- RD_REQ: ram_rd_en=1 for exactly one cycle, ram_addr=addr. Go RD_WAIT.
- RD_WAIT: wait RAM_LAT-1 further cycles so that ram_rdata is valid in LOAD.
- LOAD: shift_reg<=ram_rdata, byte_idx<=0. Go SEND.
- SEND:
  - Only when tx_busy=0: tx_start=1 for one cycle, tx_data<=shift_reg[7:0], shift_reg shifts right by 8. Go WAIT_HI.
  - If tx_busy=1, hold in SEND.
- WAIT_HI: wait for tx_busy=1, i.e. the UART has accepted the byte. Go WAIT_LO.
- WAIT_LO: wait for tx_busy=0.
  - byte_idx<2: increment byte_idx, go SEND.
  - Otherwise go NEXT.
- NEXT: addr<=addr+1 (wraps at 2^ADDR_W), words_left<=words_left-1.
  - Result nonzero: go RD_REQ.
  - Otherwise go FINISH.
- FINISH: done=1 for one cycle. Go IDLE.
- tx_data is registered and held stable from tx_start until the next SEND.
- ram_addr holds its last value when not reading.
- busy is 1 in every state except IDLE; it drops in the cycle after FINISH.
- Per-word minimum: 1 + RAM_LAT + 3×(tx handshake) + 1 cycles. There is no overlap between the RAM read and the transmission of the previous word.

Optional Feature:
- Macro: RAM_WORD_SENDER_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR of every transmitted byte, cleared on start acceptance.
  - After the last word's third byte, the block enters state CSUM. It sends the XOR byte with the same SEND/WAIT_HI/WAIT_LO handshake, then goes to FINISH.
  - word_count=0 still skips straight to FINISH with no checksum byte.
- Not defined: no CSUM state, no XOR register; the block goes NEXT→FINISH directly.

Decomposition:
- Package ram_word_sender_pkg: state enum typedef, BYTES_PER_WORD=3, BYTE_W=8.
- One sub-module, tx_byte_handshake: implements SEND/WAIT_HI/WAIT_LO for a single byte (go, byte in; tx_start, tx_data, byte_done out). It is reused for the checksum byte.

Test Plan:
- RAM[5]=0xA1B2C3, start with base_addr=5, word_count=1, model UART busy 10 cycles → tx bytes C3, B2, A1 in order; one ram_rd_en at addr 5; done pulses once; busy low afterwards.
- base_addr=0x3FE, word_count=3 → reads at 0x3FE, 0x3FF, 0x000 (wrap); 9 tx_start pulses; done once.
- start with word_count=0 → done pulse 2 cycles after start; no ram_rd_en, no tx_start.
- tx_busy forced high on entry to SEND for 50 cycles → no tx_start until tx_busy=0; start pulse arriving mid-transfer is ignored (byte count unchanged).
- reset driven low during WAIT_LO of word 2 → all outputs 0 asynchronously; after release, a new start with base 0, count 1 behaves normally.
- CHECKSUM_EN defined, words 0x010203 and 0x040506 → bytes 03 02 01 06 05 04 then 0x07 (XOR of the six bytes); done after the 7th byte.
